// File: rtl/v_rams_rd_defs_pkg.sv
// Shared defaults and state encoding for the 64x16 distributed-RAM stream reader.
package v_rams_rd_defs;

  localparam int RD_AW = 6;
  localparam int RD_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/v_rams_rd_outreg.sv
// Output register stage of the stream reader: loads a word on capture and
// holds it while the sink stalls.
module v_rams_rd_outreg
  import v_rams_rd_defs::*;
#(
  parameter int DW = RD_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_i,
  input  logic          clr_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;

  // A capture always wins over a clear: it replaces the accepted word in the same edge.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (cap_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/v_rams_stream_reader.sv
// Walks len consecutive RAM addresses from base (mod 2^AW) through the async
// read port and streams the words out on a valid/ready interface.
module v_rams_stream_reader
  import v_rams_rd_defs::*;
#(
  parameter int AW = RD_AW,
  parameter int DW = RD_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          done
);

  rd_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          done_q, done_d;

  logic          cap;
  logic          clr;
  logic          last_word;
  logic          handshake;

  assign handshake = out_valid & out_ready;
  assign last_word = (rem_q == (AW+1)'(1));

  // rem is one bit wider than ptr so that a full-depth block can be counted.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    cap     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = ST_READ;
            ptr_d   = base;
            rem_d   = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        cap = ~out_valid | out_ready;
        if (cap) begin
          ptr_d = ptr_q + AW'(1);
          rem_d = rem_q - (AW+1)'(1);
          if (last_word) begin
            state_d = ST_DRAIN;
          end
        end else if (handshake) begin
          clr = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (handshake) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  v_rams_rd_outreg #(
    .DW(DW)
  ) u_outreg (
    .clk    (clk),
    .rst    (rst),
    .cap_i  (cap),
    .clr_i  (clr),
    .data_i (rd_data),
    .last_i (last_word),
    .valid_o(out_valid),
    .data_o (out_data),
    .last_o (out_last)
  );

  assign busy    = (state_q != ST_IDLE);
  assign rd_addr = ptr_q;
  assign done    = done_q;

endmodule
